// File: rtl/keccak_sponge_ctrl_if.sv
// Bundle for the sponge controller: message lanes in, permutation core handshake, digest lanes out.
// The slave modport is the controller's view; master is the host/core/sink side.
interface keccak_sponge_ctrl_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0]            in_data;
  logic [3:0]                  in_nbytes;
  logic                        in_last;
  logic                        in_valid;
  logic                        in_ready;
  logic                        perm_start;
  logic [0:4][0:4][WIDTH-1:0]  perm_state_in;
  logic                        perm_done;
  logic [0:4][0:4][WIDTH-1:0]  perm_state_out;
  logic [WIDTH-1:0]            out_data;
  logic                        out_valid;
  logic                        out_last;
  logic                        out_ready;

  modport slave (
    input  in_data, in_nbytes, in_last, in_valid,
    output in_ready,
    output perm_start, perm_state_in,
    input  perm_done, perm_state_out,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport master (
    output in_data, in_nbytes, in_last, in_valid,
    input  in_ready,
    input  perm_start, perm_state_in,
    output perm_done, perm_state_out,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Lane-serial SHA3 sponge controller: absorb with pad10*1 (domain 0x06), sequence the permutation, squeeze.
// Optional KECCAK_CTRL_TIMEOUT_EN adds o_perm_err and an 8-bit PERM_WAIT watchdog.
module keccak_sponge_ctrl #(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  keccak_sponge_ctrl_if.slave  bus,
  output logic                 o_busy
`ifdef KECCAK_CTRL_TIMEOUT_EN
  ,
  output logic                 o_perm_err
`endif
);

  typedef enum logic [2:0] {ABSORB, PAD, PERM_REQ, PERM_WAIT, SQUEEZE} state_t;
  typedef logic [0:4][0:4][WIDTH-1:0] sponge_t;

  localparam logic [4:0] RATE_CNT  = 5'(RATE_LANES);
  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] OUT_LAST  = 5'(OUT_LANES - 1);
  localparam int         PAD_X     = (RATE_LANES - 1) % 5;
  localparam int         PAD_Y     = (RATE_LANES - 1) / 5;

  state_t           r_state, w_state_nxt;
  sponge_t          r_s, w_s_nxt;
  logic [4:0]       r_lane_cnt, w_lane_cnt_nxt;
  logic [4:0]       r_out_idx, w_out_idx_nxt;
  logic             r_pad_pend, w_pad_pend_nxt;
  logic             r_msg_done, w_msg_done_nxt;
  logic             r_run;
  logic [WIDTH-1:0] w_in_word;
  logic [WIDTH-1:0] w_out_lane;
`ifdef KECCAK_CTRL_TIMEOUT_EN
  logic [7:0]       r_wdog, w_wdog_nxt;
  logic             r_perm_err, w_perm_err_nxt;
`endif

  // Bytes past nbytes on the final lane are dropped; the first dropped byte carries the domain 0x06.
  always_comb begin
    w_in_word = '0;
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (!bus.in_last || bus.in_nbytes > 4'(b))
        w_in_word[8*b +: 8] = bus.in_data[8*b +: 8];
      else if (bus.in_nbytes == 4'(b))
        w_in_word[8*b +: 8] = 8'h06;
    end
  end

  always_comb begin
    w_out_lane = '0;
    for (int i = 0; i < OUT_LANES; i++)
      if (r_out_idx == 5'(i)) w_out_lane = r_s[i % 5][i / 5];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_lane_cnt_nxt = r_lane_cnt;
    w_out_idx_nxt  = r_out_idx;
    w_pad_pend_nxt = r_pad_pend;
    w_msg_done_nxt = r_msg_done;
`ifdef KECCAK_CTRL_TIMEOUT_EN
    w_wdog_nxt     = r_wdog;
    w_perm_err_nxt = r_perm_err;
`endif
    case (r_state)
      ABSORB: begin
        if (r_run && bus.in_valid) begin
          for (int i = 0; i < RATE_LANES; i++)
            if (r_lane_cnt == 5'(i)) w_s_nxt[i % 5][i / 5] = r_s[i % 5][i / 5] ^ w_in_word;
          w_lane_cnt_nxt = r_lane_cnt + 5'd1;
          if (bus.in_last) begin
            w_state_nxt = PAD;
            if (bus.in_nbytes < 4'd8) w_msg_done_nxt = 1'b1;
            else                      w_pad_pend_nxt = 1'b1;
          end else if (r_lane_cnt == LAST_RATE) begin
            w_state_nxt    = PERM_REQ;
            w_lane_cnt_nxt = '0;
          end
        end
      end
      PAD: begin
        // A full final block is permuted first; the domain byte then opens an otherwise empty block.
        if (r_pad_pend && r_lane_cnt == RATE_CNT) begin
          w_lane_cnt_nxt = '0;
        end else begin
          if (r_pad_pend) begin
            for (int i = 0; i < RATE_LANES; i++)
              if (r_lane_cnt == 5'(i)) w_s_nxt[i % 5][i / 5][7:0] = r_s[i % 5][i / 5][7:0] ^ 8'h06;
            w_pad_pend_nxt = 1'b0;
            w_msg_done_nxt = 1'b1;
          end
          w_s_nxt[PAD_X][PAD_Y][WIDTH-1 -: 8] = w_s_nxt[PAD_X][PAD_Y][WIDTH-1 -: 8] ^ 8'h80;
        end
        w_state_nxt = PERM_REQ;
      end
      PERM_REQ: begin
        w_state_nxt = PERM_WAIT;
`ifdef KECCAK_CTRL_TIMEOUT_EN
        w_wdog_nxt  = '0;
`endif
      end
      PERM_WAIT: begin
        if (bus.perm_done) begin
          w_s_nxt = bus.perm_state_out;
          if (r_pad_pend) begin
            w_state_nxt = PAD;
          end else if (r_msg_done) begin
            w_state_nxt   = SQUEEZE;
            w_out_idx_nxt = '0;
          end else begin
            w_state_nxt = ABSORB;
          end
        end
`ifdef KECCAK_CTRL_TIMEOUT_EN
        else begin
          w_wdog_nxt = r_wdog + 8'd1;
          if (w_wdog_nxt == 8'hFF) begin
            w_perm_err_nxt = 1'b1;
            w_s_nxt        = '0;
            w_lane_cnt_nxt = '0;
            w_out_idx_nxt  = '0;
            w_pad_pend_nxt = 1'b0;
            w_msg_done_nxt = 1'b0;
            w_state_nxt    = ABSORB;
          end
        end
`endif
      end
      SQUEEZE: begin
        if (bus.out_ready) begin
          if (r_out_idx == OUT_LAST) begin
            w_s_nxt        = '0;
            w_lane_cnt_nxt = '0;
            w_out_idx_nxt  = '0;
            w_msg_done_nxt = 1'b0;
            w_state_nxt    = ABSORB;
          end else begin
            w_out_idx_nxt = r_out_idx + 5'd1;
          end
        end
      end
      default: w_state_nxt = ABSORB;
    endcase
  end

  // r_run keeps in_ready low through reset without a combinational path from nrst.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= ABSORB;
      r_s        <= '0;
      r_lane_cnt <= '0;
      r_out_idx  <= '0;
      r_pad_pend <= 1'b0;
      r_msg_done <= 1'b0;
      r_run      <= 1'b0;
`ifdef KECCAK_CTRL_TIMEOUT_EN
      r_wdog     <= '0;
      r_perm_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_lane_cnt <= w_lane_cnt_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_pad_pend <= w_pad_pend_nxt;
      r_msg_done <= w_msg_done_nxt;
      r_run      <= 1'b1;
`ifdef KECCAK_CTRL_TIMEOUT_EN
      r_wdog     <= w_wdog_nxt;
      r_perm_err <= w_perm_err_nxt;
`endif
    end
  end

  assign bus.in_ready      = (r_state == ABSORB) && r_run;
  assign bus.perm_start    = (r_state == PERM_REQ);
  assign bus.perm_state_in = r_s;
  assign bus.out_valid     = (r_state == SQUEEZE);
  assign bus.out_last      = (r_state == SQUEEZE) && (r_out_idx == OUT_LAST);
  assign bus.out_data      = (r_state == SQUEEZE) ? w_out_lane : '0;
  assign o_busy            = (r_state != ABSORB) || (r_lane_cnt != 5'd0);
`ifdef KECCAK_CTRL_TIMEOUT_EN
  assign o_perm_err        = r_perm_err;
`endif

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Directed self-checking bench for keccak_sponge_ctrl; the bench plays host, permutation core and digest sink.
// The core answers with a seeded fixed pattern so every post-permutation lane is known in advance.
module tb_keccak_sponge_ctrl;

  logic clk;
  logic nrst;
  logic o_busy;
`ifdef KECCAK_CTRL_TIMEOUT_EN
  logic o_perm_err;
`endif
  int nChecks = 0;
  int nFail   = 0;
  int nStarts = 0;
  int startsBefore;

  keccak_sponge_ctrl_if #(.WIDTH(64)) ifc ();

  keccak_sponge_ctrl #(.WIDTH(64), .RATE_LANES(17), .OUT_LANES(4)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .bus    (ifc),
    .o_busy (o_busy)
`ifdef KECCAK_CTRL_TIMEOUT_EN
    ,
    .o_perm_err (o_perm_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ifc.perm_start === 1'b1) nStarts++;

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: observed hang expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic logic [63:0] laneData(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h12345678 ^ 32'(i)};
  endfunction

  function automatic logic [63:0] pLane(input int k, input int seed);
    return {8'(seed), 24'hC3A55A, 32'hF00D0000 | 32'(k)};
  endfunction

  function automatic logic [63:0] laneOf(input logic [0:4][0:4][63:0] st, input int k);
    return st[k % 5][k / 5];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic [3:0] nbytes, input logic last);
    checkOutput("in_ready before lane", 64'(ifc.in_ready), 64'd1);
    ifc.in_data   = data;
    ifc.in_nbytes = nbytes;
    ifc.in_last   = last;
    ifc.in_valid  = 1'b1;
    tick();
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.in_data   = 64'hBAD0BAD0BAD0BAD0;
  endtask

  task automatic waitStart(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (ifc.perm_start === 1'b1) break;
      tick();
    end
    checkOutput(tag, 64'(ifc.perm_start), 64'd1);
  endtask

  // Called in the PERM_REQ cycle; answers after one idle PERM_WAIT cycle.
  task automatic servePerm(input int seed);
    logic [0:4][0:4][63:0] ps;
    tick();
    checkOutput("perm_start single cycle", 64'(ifc.perm_start), 64'd0);
    tick();
    for (int k = 0; k < 25; k++) ps[k % 5][k / 5] = pLane(k, seed);
    ifc.perm_state_out = ps;
    ifc.perm_done      = 1'b1;
    tick();
    ifc.perm_done      = 1'b0;
  endtask

  task automatic drainDigest(input int seed, input logic stall);
    int idx = 0;
    logic rdy;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      checkOutput("out_valid in squeeze", 64'(ifc.out_valid), 64'd1);
      checkOutput("out_data lane", ifc.out_data, pLane(idx, seed));
      checkOutput("out_last", 64'(ifc.out_last), (idx == 3) ? 64'd1 : 64'd0);
      rdy = stall ? ((c % 2) == 1) : 1'b1;
      ifc.out_ready = rdy;
      tick();
      if (rdy) idx++;
    end
    ifc.out_ready = 1'b0;
    checkOutput("digest lanes drained", 64'(idx), 64'd4);
    checkOutput("out_valid after digest", 64'(ifc.out_valid), 64'd0);
    checkOutput("in_ready after digest", 64'(ifc.in_ready), 64'd1);
    checkOutput("busy after digest", 64'(o_busy), 64'd0);
  endtask

  initial begin
    nrst               = 1'b0;
    ifc.in_data        = '0;
    ifc.in_nbytes      = '0;
    ifc.in_last        = 1'b0;
    ifc.in_valid       = 1'b0;
    ifc.perm_done      = 1'b0;
    ifc.perm_state_out = '0;
    ifc.out_ready      = 1'b0;
    @(negedge clk);
    repeat (3) tick();

    $display("[TB] reset values");
    checkOutput("reset in_ready", 64'(ifc.in_ready), 64'd0);
    checkOutput("reset busy", 64'(o_busy), 64'd0);
    checkOutput("reset perm_start", 64'(ifc.perm_start), 64'd0);
    checkOutput("reset out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("reset out_last", 64'(ifc.out_last), 64'd0);
    checkOutput("reset out_data", ifc.out_data, 64'd0);
    nrst = 1'b1;
    tick();
    checkOutput("in_ready after release", 64'(ifc.in_ready), 64'd1);

    $display("[TB] empty message");
    startsBefore = nStarts;
    applyStimulus(64'hDEADBEEFCAFEF00D, 4'd0, 1'b1);
    checkOutput("no start in PAD", 64'(ifc.perm_start), 64'd0);
    tick();
    checkOutput("start 2 cycles after accept", 64'(ifc.perm_start), 64'd1);
    checkOutput("empty lane0", laneOf(ifc.perm_state_in, 0), 64'h0000000000000006);
    checkOutput("empty lane16", laneOf(ifc.perm_state_in, 16), 64'h8000000000000000);
    servePerm(7);
    checkOutput("empty start count", 64'(nStarts - startsBefore), 64'd1);
    drainDigest(7, 1'b0);

    $display("[TB] 8-byte message");
    applyStimulus(64'h1122334455667788, 4'd8, 1'b1);
    waitStart("8-byte start");
    checkOutput("8-byte lane0", laneOf(ifc.perm_state_in, 0), 64'h1122334455667788);
    checkOutput("8-byte lane1", laneOf(ifc.perm_state_in, 1), 64'h0000000000000006);
    checkOutput("8-byte lane16", laneOf(ifc.perm_state_in, 16), 64'h8000000000000000);
    servePerm(3);
    drainDigest(3, 1'b0);

    $display("[TB] 7-byte message");
    applyStimulus(64'hFFEEDDCCBBAA9988, 4'd7, 1'b1);
    waitStart("7-byte start");
    checkOutput("7-byte lane0", laneOf(ifc.perm_state_in, 0), 64'h06EEDDCCBBAA9988);
    checkOutput("7-byte lane1", laneOf(ifc.perm_state_in, 1), 64'h0);
    servePerm(4);
    drainDigest(4, 1'b0);

    $display("[TB] 136-byte message with digest backpressure");
    startsBefore = nStarts;
    for (int i = 0; i < 16; i++) applyStimulus(laneData(i), 4'd8, 1'b0);
    checkOutput("busy mid-block", 64'(o_busy), 64'd1);
    applyStimulus(laneData(16), 4'd8, 1'b1);
    waitStart("full block start");
    checkOutput("block1 lane0", laneOf(ifc.perm_state_in, 0), laneData(0));
    checkOutput("block1 lane7", laneOf(ifc.perm_state_in, 7), laneData(7));
    checkOutput("block1 lane16", laneOf(ifc.perm_state_in, 16), laneData(16));
    servePerm(1);
    waitStart("pad block start");
    checkOutput("block2 lane0", laneOf(ifc.perm_state_in, 0), pLane(0, 1) ^ 64'h06);
    checkOutput("block2 lane5", laneOf(ifc.perm_state_in, 5), pLane(5, 1));
    checkOutput("block2 lane16", laneOf(ifc.perm_state_in, 16), pLane(16, 1) ^ 64'h8000000000000000);
    servePerm(2);
    checkOutput("136-byte start count", 64'(nStarts - startsBefore), 64'd2);
    drainDigest(2, 1'b1);

    $display("[TB] partial final lane in the rate lane");
    for (int i = 0; i < 16; i++) applyStimulus(laneData(i + 40), 4'd8, 1'b0);
    applyStimulus(64'h7766554433221100, 4'd7, 1'b1);
    waitStart("rate-lane start");
    checkOutput("rate lane 0x86", laneOf(ifc.perm_state_in, 16), 64'h8666554433221100);
    checkOutput("rate-lane lane15", laneOf(ifc.perm_state_in, 15), laneData(55));
    servePerm(9);
    drainDigest(9, 1'b0);

    $display("[TB] reset during PERM_WAIT");
    applyStimulus(64'h0, 4'd0, 1'b1);
    waitStart("pre-reset start");
    tick();
    checkOutput("busy in PERM_WAIT", 64'(o_busy), 64'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int k = 0; k < 25; k++) ifc.perm_state_out[k % 5][k / 5] = pLane(k, 5);
    ifc.perm_done = 1'b1;
    tick();
    ifc.perm_done = 1'b0;
    checkOutput("post-reset out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("post-reset in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("post-reset lane0", laneOf(ifc.perm_state_in, 0), 64'h0);
    checkOutput("post-reset busy", 64'(o_busy), 64'd0);
    tick();
    checkOutput("late done ignored out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("late done ignored lane1", laneOf(ifc.perm_state_in, 1), 64'h0);

`ifdef KECCAK_CTRL_TIMEOUT_EN
    $display("[TB] permutation watchdog");
    applyStimulus(64'h0, 4'd0, 1'b1);
    waitStart("watchdog start");
    tick();
    checkOutput("perm_err early", 64'(o_perm_err), 64'd0);
    repeat (254) tick();
    checkOutput("perm_err before expiry", 64'(o_perm_err), 64'd0);
    tick();
    checkOutput("perm_err at expiry", 64'(o_perm_err), 64'd1);
    checkOutput("in_ready after expiry", 64'(ifc.in_ready), 64'd1);
    checkOutput("busy after expiry", 64'(o_busy), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/keccak_sponge_ctrl.md
# keccak_sponge_ctrl

Lane-serial sponge controller for the SHA3 datapath. It absorbs a byte-granular message as a stream of 64-bit lanes, applies SHA3 pad10*1 with domain byte 0x06, and sequences the 24-round permutation core over a 1600-bit state through a start/done handshake. It then streams the digest lanes out. It sits between the host-side message interface and the permutation core, and owns the state register, lane counter and block sequencing.

## Interface
- WIDTH, 64, lane width in bits; only 64 is supported.
- RATE_LANES, 17, rate in lanes (17 = SHA3-256, 9 = SHA3-512); legal range 1..21.
- OUT_LANES, 4, digest lanes emitted; must be ≤ RATE_LANES.
- clk  in  1  single clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_data  in  WIDTH  message lane, little-endian (byte 0 = bits [7:0]).
- in_nbytes  in  4  valid bytes in the lane, 0..8; sampled only with in_last, otherwise treated as 8.
- in_last  in  1  lane is the final lane of the message.
- in_valid  in  1  lane present.
- in_ready  out  1  controller accepts a lane this cycle.
- perm_start  out  1  one-cycle pulse that launches the permutation.
- perm_state_in  out  [0:4][0:4][WIDTH-1:0]  state presented to the core.
- perm_done  in  1  core result valid this cycle.
- perm_state_out  in  [0:4][0:4][WIDTH-1:0]  permuted state.
- out_data  out  WIDTH  digest lane.
- out_valid  out  1  digest lane valid.
- out_last  out  1  final digest lane.
- out_ready  in  1  sink accepts digest lane.
- busy  out  1  high whenever state ≠ ABSORB or the lane count is non-zero.

## Operation
- Lane mapping: lane i goes to S[x][y], with x = i mod 5 and y = i div 5.
- States:
  - ABSORB, PAD, PERM_REQ, PERM_WAIT, SQUEEZE. Reset enters ABSORB with S = 0, lane_cnt = 0, pad_pend = 0, msg_done = 0.
- ABSORB:
  - in_ready = 1.
  - On each accept, S[lane_cnt] ^= in_data masked to the valid bytes, then lane_cnt++.
  - Non-last lane, lane_cnt reaches RATE_LANES: go to PERM_REQ with lane_cnt = 0.
  - in_last with nbytes < 8: XOR 0x06 at byte nbytes of the same lane, set msg_done, go to PAD.
  - in_last with nbytes = 8: set pad_pend, go to PAD.
- PAD (one cycle):
  - If pad_pend: XOR 0x06 into byte 0 of lane lane_cnt, clear pad_pend, set msg_done.
    - If lane_cnt is already RATE_LANES (the block was full), first go to PERM_REQ with pad_pend kept. The post-permutation path then returns to PAD with lane_cnt = 0.
  - Then XOR 0x80 into byte 7 of lane RATE_LANES-1. Both XORs land in the same lane when it is the pad lane, so the byte can become 0x86. Go to PERM_REQ.
- PERM_REQ: perm_start = 1 for exactly one cycle, then go to PERM_WAIT.
- PERM_WAIT: on perm_done, S ← perm_state_out, then:
  - pad_pend set: go to PAD.
  - msg_done set: go to SQUEEZE with out_idx = 0.
  - Otherwise: go to ABSORB.
- SQUEEZE:
  - out_data = S[out_idx], out_valid = 1, out_last = (out_idx == OUT_LANES-1).
  - On out_valid & out_ready: out_idx++.
  - On the last lane: clear S, lane_cnt, msg_done; go to ABSORB.
- perm_state_in is driven from S continuously. S does not change in PERM_REQ or PERM_WAIT.
- perm_done is ignored in every state except PERM_WAIT.
- in_valid is ignored outside ABSORB.

## Timing
- Reset values: in_ready 0 while nrst = 0; 1 in the first cycle after release. perm_start 0, out_valid 0, out_last 0, out_data 0, busy 0.
- in_ready, out_valid, out_last, perm_start and busy are decoded from registered state only. There is no combinational path from any input.
- Absorb throughput: one lane per cycle.
- Last-lane accept to perm_start: 2 cycles (PAD, then PERM_REQ).
- perm_done to first out_valid: 1 cycle.
- out_data is held stable while out_valid = 1 and out_ready = 0.
- Reset asserted in any state, including PERM_WAIT: the next edge returns to ABSORB with all registers cleared. A later perm_done from the core is ignored.

## Configuration
- KECCAK_CTRL_TIMEOUT_EN defined:
  - Adds output perm_err (1 bit, reset 0) and an 8-bit watchdog.
  - The watchdog clears on PERM_REQ and counts in PERM_WAIT.
  - At count 255 with no perm_done: perm_err goes high and sticks until reset; the FSM clears S and counters and goes to ABSORB.
- Undefined: no perm_err port and no watchdog; PERM_WAIT waits indefinitely.

## Test plan
- Empty message: in_last with nbytes = 0 at lane 0.
  - Expect perm_state_in lane 0 = 0x0000000000000006 and lane 16 = 0x8000000000000000.
  - Expect exactly one perm_start, 2 cycles after accept.
- 8-byte message 0x1122334455667788 with nbytes = 8:
  - Expect lane 0 = 0x1122334455667788, lane 1 = 0x06, lane 16 = 0x80<<56.
- 136-byte message, 17 full lanes, last with nbytes = 8:
  - Expect two perm_starts.
  - The second block is lane 0 = 0x06 XOR permuted-S lane 0, and lane 16 gets 0x80 in its top byte.
- Digest backpressure: drop out_ready on alternate cycles.
  - Expect 4 lanes with out_data stable while stalled, out_last on lane 3, then in_ready = 1.
- Reset in PERM_WAIT, then inject perm_done:
  - Expect no state update, no out_valid, and in_ready = 1 after reset release.
- With KECCAK_CTRL_TIMEOUT_EN defined, hold perm_done low:
  - Expect perm_err = 1 at the 255th PERM_WAIT cycle and a return to ABSORB.
